// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: operand handshake in, result handshake out.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, alu_control, input1, input2, out_ready,
    input  in_ready, out_valid, alu_result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, alu_control, input1, input2, out_ready,
    output in_ready, out_valid, alu_result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/MULHU.
// Define ALU_DIV_EN to build the restoring divider for DIVU/REMU; otherwise they are illegal.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic               hi_sel;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   result;
  logic               zero_r;
  logic               ovf_r;
  logic               ill_r;
`ifdef ALU_DIV_EN
  logic               div_sel;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
`endif

  logic [WIDTH-1:0] a, b, sum, diff, sc_result, fin;
  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   psum;
  logic             sc_ovf, sc_ill, multi;

  assign a     = bus.input1;
  assign b     = bus.input2;
  assign shamt = b[SW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.alu_result = result;
  assign bus.zero       = zero_r;
  assign bus.overflow   = ovf_r;
  assign bus.illegal    = ill_r;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_ill    = 1'b0;
    multi     = 1'b0;
    case (bus.alu_control)
      4'b0000: sc_result = a & b;
      4'b0001: sc_result = a | b;
      4'b0010: begin
        sc_result = sum;
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0011: sc_result = a ^ b;
      4'b0100: sc_result = a << shamt;
      4'b0101: sc_result = a >> shamt;
      4'b0110: begin
        sc_result = diff;
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1000: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1001: sc_result = $unsigned($signed(a) >>> shamt);
      4'b1010: sc_result = ~(a | b);
      4'b1100, 4'b1101: multi = 1'b1;
      4'b1110, 4'b1111: begin
`ifdef ALU_DIV_EN
        // Divide by zero resolves immediately: quotient all ones, remainder = dividend.
        if (b == '0) sc_result = bus.alu_control[0] ? a : '1;
        else         multi     = 1'b1;
`else
        sc_ill = 1'b1;
`endif
      end
      default: sc_ill = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply, or restoring divide when div_sel is set.
  always_comb begin
    psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    acc_next = {psum, acc[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    trial  = rem_sh - {1'b0, opb};
    if (div_sel) begin
      acc_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Upper half holds MULHU product / remainder, lower half MUL product / quotient.
  assign fin = hi_sel ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi_sel  <= 1'b0;
      opb     <= '0;
      acc     <= '0;
      count   <= '0;
      result  <= '0;
      zero_r  <= 1'b0;
      ovf_r   <= 1'b0;
      ill_r   <= 1'b0;
`ifdef ALU_DIV_EN
      div_sel <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            hi_sel  <= bus.alu_control[0];
            opb     <= b;
`ifdef ALU_DIV_EN
            div_sel <= bus.alu_control[1];
`endif
            if (multi) begin
              acc   <= {{WIDTH{1'b0}}, a};
              count <= CW'(WIDTH);
              state <= BUSY;
            end else begin
              result <= sc_result;
              zero_r <= (sc_result == '0);
              ovf_r  <= sc_ovf;
              ill_r  <= sc_ill;
              state  <= DONE;
            end
          end
        end
        BUSY: begin
          acc   <= acc_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result <= fin;
            zero_r <= (fin == '0);
            ovf_r  <= 1'b0;
            ill_r  <= 1'b0;
            state  <= DONE;
          end
        end
        DONE:    if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed vectors push expectations, a negedge monitor checks them.
module tb_alu_mc;
  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(WIDTH)) bus();
  alu_mc #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        i;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   accept_edge = 0;
  bit   pending = 0, seen = 0, post_hs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic finish_now();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic timeout(input string what);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s: got no response expected one within bound", what);
    finish_now();
  endtask

  // Monitor: samples on the falling edge, compares against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      pending = 0;
      seen    = 0;
      post_hs = 0;
    end else begin
      if (post_hs) begin
        check("in_ready after handshake", bus.in_ready, 1);
        post_hs = 0;
      end
      if (pending && !bus.out_valid && cyc >= accept_edge)
        check("in_ready while busy", bus.in_ready, 0);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected out_valid: got 1 expected 0");
        end else begin
          cur = sb[0];
          if (!seen) begin
            check("latency", 64'(cyc - accept_edge + 1), 64'(cur.lat));
            seen = 1;
          end
          check("alu_result", bus.alu_result, cur.res);
          check("zero", bus.zero, cur.z);
          check("overflow", bus.overflow, cur.o);
          check("illegal", bus.illegal, cur.i);
          check("in_ready in DONE", bus.in_ready, 0);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            pending = 0;
            seen    = 0;
            post_hs = 1;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        accept_edge = cyc + 1;
        pending     = 1;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic z, input logic o, input logic i,
                      input int lat);
    exp_t e;
    bit   got;
    e.res = res; e.z = z; e.o = o; e.i = i; e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.input1      = a;
    bus.input2      = b;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    if (!got) timeout("accept");
    @(posedge clk); #1;
    // Scramble request fields after acceptance; the DUT must ignore them.
    bus.in_valid    = 1'b0;
    bus.alu_control = ~op;
    bus.input1      = ~a;
    bus.input2      = ~b;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) timeout("result");
    @(negedge clk);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic z, input logic o, input logic i,
                     input int lat);
    send(op, a, b, res, z, o, i, lat);
    wait_idle();
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'h0;
    bus.input1      = '0;
    bus.input2      = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset alu_result", bus.alu_result, 0);
    check("reset zero", bus.zero, 0);
    check("reset overflow", bus.overflow, 0);
    check("reset illegal", bus.illegal, 0);

    //   op       input1        input2        result        z  o  i  lat
    run(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 1);
    run(4'b0110, 32'd5,        32'd5,        32'h00000000, 1, 0, 0, 1);
    run(4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 0, 1);
    run(4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 1);
    run(4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0, 1);
    run(4'b1001, 32'h80000000, 32'h00000024, 32'hF8000000, 0, 0, 0, 1);
    run(4'b0000, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 0, 0, 0, 1);
    run(4'b0001, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 0, 0, 0, 1);
    run(4'b0011, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 0, 0, 0, 1);
    run(4'b1010, 32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000, 0, 0, 0, 1);
    run(4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 0, 0, 0, 1);
    run(4'b0101, 32'h80000000, 32'h00000021, 32'h40000000, 0, 0, 0, 1);
    run(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 33);
    run(4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 33);
    run(4'b1100, 32'h00012345, 32'h00000010, 32'h00123450, 0, 0, 0, 33);
`ifdef ALU_DIV_EN
    run(4'b1110, 32'd100, 32'd7, 32'd14,         0, 0, 0, 33);
    run(4'b1111, 32'd100, 32'd7, 32'd2,          0, 0, 0, 33);
    run(4'b1110, 32'd100, 32'd0, 32'hFFFFFFFF,   0, 0, 0, 1);
    run(4'b1111, 32'd100, 32'd0, 32'd100,        0, 0, 0, 1);
`else
    run(4'b1110, 32'd100, 32'd7, 32'd0,          1, 0, 1, 1);
    run(4'b1111, 32'd100, 32'd0, 32'd0,          1, 0, 1, 1);
`endif

    // Backpressure: hold the result for several cycles before accepting it.
    bus.out_ready = 1'b0;
    send(4'b0010, 32'd3, 32'd4, 32'd7, 0, 0, 0, 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a multiply aborts it and clears all outputs.
    send(4'b1100, 32'd3, 32'd5, 32'd15, 0, 0, 0, 33);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort in_ready", bus.in_ready, 1);
    check("abort out_valid", bus.out_valid, 0);
    check("abort alu_result", bus.alu_result, 0);
    check("abort illegal", bus.illegal, 0);
    repeat (3) @(negedge clk);

    run(4'b1011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 1, 1);
    run(4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0, 1);

    finish_now();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected one before time limit");
    n_fail++;
    finish_now();
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, handshaked, multi-cycle ALU for the execute stage; WIDTH-bit operands.
- Opcode set extended with XOR/NOR, shifts, signed/unsigned compare, iterative multiply and unsigned divide.
- Single-cycle ops return one cycle after acceptance; MUL/DIV ops take WIDTH+1 cycles. The stage stalls on in_ready.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 4; shift amount = low $clog2(WIDTH) bits of input2

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept; high only in IDLE
- alu_control  input  4  opcode
- input1  input  WIDTH  operand A
- input2  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- alu_result  output  WIDTH  result, registered
- zero  output  1  alu_result == 0
- overflow  output  1  signed overflow, ADD/SUB only, else 0
- illegal  output  1  undefined opcode

Behaviour:
- Interface: clk and rst_n; reset synchronous, active-low, one clock.
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 SRA, 1010 NOR, 1011 undefined, 1100 MUL (low WIDTH of product), 1101 MULHU (high WIDTH, unsigned), 1110 DIVU, 1111 REMU.
- SLT/SLTU result is zero-extended 1 or 0. ADD/SUB wrap modulo 2^WIDTH. Overflow = operand signs equal (ADD) or different (SUB) and result sign differs from input1.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid, latch opcode and operands.
  - Single-cycle op, undefined op, or divide by zero: compute and go to DONE (out_valid next cycle).
  - MUL/MULHU/DIVU/REMU with nonzero divisor: go to BUSY and load the counter with WIDTH.
- BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle, with a 2*WIDTH accumulator. The counter decrements each cycle. At count 1, write the result and go to DONE. out_valid asserts WIDTH+1 cycles after the accept edge. in_ready=0.
- DONE: out_valid=1. alu_result, zero, overflow and illegal are held stable until out_ready=1. On handshake, go to IDLE. in_ready stays 0 in DONE, so no same-cycle accept; minimum issue interval is 2 cycles.
- Divide by zero: DIVU gives all ones; REMU gives input1. Latency 1; no flag.
- Undefined opcode 1011: result 0, illegal=1, zero=1, latency 1.
- Operand/opcode changes while in_ready=0 are ignored.
- Reset: rst_n low at any edge, in any state, aborts the operation. FSM goes to IDLE; out_valid=0, alu_result=0, zero=0, overflow=0, illegal=0, counter=0. in_ready=1 in the first cycle after reset.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: DIVU/REMU are implemented as above.
- Undefined: no divider logic is built. 1110/1111 behave as undefined opcodes: result 0, illegal=1, latency 1.
- MUL/MULHU are always present.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> alu_result 0x80000000, overflow=1, zero=0, out_valid one cycle after accept. SUB 5-5 -> 0, zero=1, overflow=0.
- SLT 0xFFFFFFFF,0x00000001 -> 1. SLTU same operands -> 0. SRA 0x80000000 by 0x24 (shamt 4) -> 0xF8000000.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU same -> 0xFFFFFFFE. out_valid exactly 33 cycles after accept edge; in_ready=0 throughout.
- ALU_DIV_EN defined: DIVU 100/7 -> 14 and REMU -> 2, each after 33 cycles. DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each after 1 cycle. Macro undefined: DIVU -> 0, illegal=1.
- Backpressure: out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0. Raise out_ready -> handshake; in_ready=1 next cycle.
- rst_n low for one cycle mid-MUL (cycle 10 of BUSY) -> next cycle in_ready=1, out_valid=0, alu_result=0. Opcode 1011 -> result 0, illegal=1.
